// File: rtl/ga_pkg.sv
// Shared types and constants for the video pixel path: pen type, palette layout,
// CPU register function codes and the mode-dependent pen extraction.
package ga_pkg;

  localparam logic [4:0] BLANK_COLOUR = 5'h14;
  localparam int         PAL_ENTRIES  = 17;

  typedef logic [4:0] pen_t;

  localparam pen_t       BORDER_INDEX = 5'd16;
  localparam logic [1:0] FN_PEN_SEL   = 2'b00;
  localparam logic [1:0] FN_INK       = 2'b01;

  // Mode 2 wins if both mode strobes are high; neither high means mode 1 rules (mode 3 too).
  function automatic pen_t extract_pen(input logic [7:0] sr, input logic mode_0, input logic mode_2);
    if (mode_2)
      return {4'b0000, sr[7]};
    else if (mode_0)
      return {1'b0, sr[1], sr[5], sr[3], sr[7]};
    else
      return {3'b000, sr[3], sr[7]};
  endfunction

endpackage

// File: rtl/palette_ram.sv
// 17-entry ink/border palette: one synchronous write port, one asynchronous read port.
module palette_ram
  import ga_pkg::*;
#(
  parameter int                  COLOUR_W  = 5,
  parameter logic [COLOUR_W-1:0] RESET_VAL = ga_pkg::BLANK_COLOUR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  pen_t                wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  pen_t                rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem [PAL_ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) mem[i] <= RESET_VAL;
    end else if (wr_en && (wr_addr <= BORDER_INDEX)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Addresses above the border entry never occur in practice; return the blank colour.
  assign rd_data = (rd_addr <= BORDER_INDEX) ? mem[rd_addr] : RESET_VAL;

endmodule

// File: rtl/video_pixel_path.sv
// Video byte shifter, pen extraction, palette lookup and registered colour output.
// Optional macro PEN_OUT_EN adds a registered PEN output alongside COLOUR.
module video_pixel_path
  import ga_pkg::*;
#(
  parameter int                  COLOUR_W     = 5,
  parameter logic [COLOUR_W-1:0] BLANK_COLOUR = ga_pkg::BLANK_COLOUR
) (
  input  logic                CLK_n,
  input  logic                RESET_n,
  input  logic [7:0]          D,
  input  logic                LOAD,
  input  logic                SHIFT,
  input  logic                KEEP,
  input  logic                INK_SEL,
  input  logic                BORDER_SEL,
  input  logic                COLOUR_KEEP,
  input  logic                MODE_IS_0,
  input  logic                MODE_IS_2,
  input  logic                REG_WR,
  input  logic [7:0]          REG_DATA,
  output logic [COLOUR_W-1:0] COLOUR
`ifdef PEN_OUT_EN
  ,
  output pen_t                PEN
`endif
);

  logic [7:0]          sr;
  pen_t                pen_q;
  pen_t                pen_sel;
  pen_t                rd_addr;
  logic [COLOUR_W-1:0] rd_data;
  logic [COLOUR_W-1:0] colour_d;
  logic                ink_wr;
  logic                unused_reg_bit;

  assign ink_wr         = REG_WR && (REG_DATA[7:6] == FN_INK);
  assign unused_reg_bit = REG_DATA[5];

  palette_ram #(
    .COLOUR_W  (COLOUR_W),
    .RESET_VAL (BLANK_COLOUR)
  ) u_palette (
    .clk     (CLK_n),
    .rst_n   (RESET_n),
    .wr_en   (ink_wr),
    .wr_addr (pen_sel),
    .wr_data (REG_DATA[COLOUR_W-1:0]),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Palette read is combinational, so a same-edge ink write is seen only on the next edge.
  always_comb begin
    rd_addr  = BORDER_SEL ? BORDER_INDEX : pen_q;
    colour_d = COLOUR;
    if (!COLOUR_KEEP) begin
      if (BORDER_SEL || INK_SEL) colour_d = rd_data;
      else                       colour_d = BLANK_COLOUR;
    end
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      sr      <= '0;
      pen_q   <= '0;
      pen_sel <= '0;
      COLOUR  <= BLANK_COLOUR;
    end else begin
      if (LOAD)       sr <= D;
      else if (SHIFT) sr <= {sr[6:0], 1'b0};
      if (!KEEP) pen_q <= extract_pen(sr, MODE_IS_0, MODE_IS_2);
      if (REG_WR && (REG_DATA[7:6] == FN_PEN_SEL))
        pen_sel <= REG_DATA[4] ? BORDER_INDEX : {1'b0, REG_DATA[3:0]};
      COLOUR <= colour_d;
    end
  end

`ifdef PEN_OUT_EN
  pen_t pen_d;

  always_comb begin
    pen_d = PEN;
    if (!COLOUR_KEEP) begin
      if (BORDER_SEL)   pen_d = BORDER_INDEX;
      else if (INK_SEL) pen_d = pen_q;
      else              pen_d = '0;
    end
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) PEN <= '0;
    else          PEN <= pen_d;
  end
`endif

endmodule

// File: tb/tb_video_pixel_path.sv
// Directed and random checks of video_pixel_path against an arithmetic reference model.
module tb_video_pixel_path;

  logic       CLK_n = 1'b0;
  logic       RESET_n;
  logic [7:0] D;
  logic       LOAD, SHIFT, KEEP, INK_SEL, BORDER_SEL, COLOUR_KEEP;
  logic       MODE_IS_0, MODE_IS_2, REG_WR;
  logic [7:0] REG_DATA;
  logic [4:0] COLOUR;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_sr, m_pen, m_sel, m_colour;
  int m_pal [17];

  video_pixel_path dut (
    .CLK_n       (CLK_n),
    .RESET_n     (RESET_n),
    .D           (D),
    .LOAD        (LOAD),
    .SHIFT       (SHIFT),
    .KEEP        (KEEP),
    .INK_SEL     (INK_SEL),
    .BORDER_SEL  (BORDER_SEL),
    .COLOUR_KEEP (COLOUR_KEEP),
    .MODE_IS_0   (MODE_IS_0),
    .MODE_IS_2   (MODE_IS_2),
    .REG_WR      (REG_WR),
    .REG_DATA    (REG_DATA),
    .COLOUR      (COLOUR)
  );

  always #5 CLK_n = ~CLK_n;

  function automatic int bit_of(input int v, input int i);
    return (v >> i) & 1;
  endfunction

  function automatic int model_pen(input int sr, input logic m0, input logic m2);
    if (m2)      return bit_of(sr, 7);
    else if (m0) return 8 * bit_of(sr, 1) + 4 * bit_of(sr, 5) + 2 * bit_of(sr, 3) + bit_of(sr, 7);
    else         return 2 * bit_of(sr, 3) + bit_of(sr, 7);
  endfunction

  function automatic int pal_val(input int i);
    if (i == 0)      return 20;
    else if (i == 1) return 11;
    else if (i < 11) return i;
    else             return i + 16;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input int exp);
    logic [4:0] e;
    e = exp[4:0];
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic model_reset();
    m_sr = 0; m_pen = 0; m_sel = 0; m_colour = 20;
    for (int i = 0; i < 17; i++) m_pal[i] = 20;
  endtask

  task automatic tick(input string tag);
    int nc, np, ns, fn;
    @(posedge CLK_n);
    if (COLOUR_KEEP)     nc = m_colour;
    else if (BORDER_SEL) nc = m_pal[16];
    else if (INK_SEL)    nc = m_pal[m_pen];
    else                 nc = 20;
    np = KEEP ? m_pen : model_pen(m_sr, MODE_IS_0, MODE_IS_2);
    ns = LOAD ? int'(D) : (SHIFT ? (m_sr * 2) % 256 : m_sr);
    if (REG_WR) begin
      fn = int'(REG_DATA) / 64;
      if (fn == 0)      m_sel = ((int'(REG_DATA) % 32) >= 16) ? 16 : int'(REG_DATA) % 16;
      else if (fn == 1) m_pal[m_sel] = int'(REG_DATA) % 32;
    end
    m_colour = nc; m_pen = np; m_sr = ns;
    #1;
    check(tag, COLOUR, nc);
  endtask

  task automatic reg_write(input logic [7:0] data);
    REG_WR = 1'b1; REG_DATA = data;
    tick("reg_write");
    REG_WR = 1'b0;
  endtask

  logic [4:0] exp_m2 [8];
  logic [4:0] held;

  initial begin
    exp_m2 = '{5'h0B, 5'h14, 5'h0B, 5'h14, 5'h14, 5'h0B, 5'h14, 5'h0B};
    RESET_n = 1'b0; D = '0; LOAD = 0; SHIFT = 0; KEEP = 0; INK_SEL = 0; BORDER_SEL = 0;
    COLOUR_KEEP = 0; MODE_IS_0 = 0; MODE_IS_2 = 0; REG_WR = 0; REG_DATA = '0;
    model_reset();
    #12 RESET_n = 1'b1;
    #1 check("reset_colour", COLOUR, 20);
    tick("idle");

    for (int i = 0; i < 16; i++) begin
      reg_write(8'(i));
      reg_write(8'(64 + pal_val(i)));
    end

    // mode 2 serial pixels
    MODE_IS_2 = 1; INK_SEL = 1; KEEP = 0;
    LOAD = 1; D = 8'hA5; tick("m2_load");
    LOAD = 0; SHIFT = 1; tick("m2_shift1");
    for (int k = 0; k < 8; k++) begin
      SHIFT = (k < 6);
      tick("m2_step");
      check("m2_sequence", COLOUR, int'(exp_m2[k]));
    end
    SHIFT = 0;

    // mode 1, shift every other cycle, keep on alternate cycles
    MODE_IS_2 = 0;
    LOAD = 1; D = 8'h88; tick("m1_load");
    LOAD = 0;
    for (int c = 0; c < 9; c++) begin
      SHIFT = (c % 2 == 1); KEEP = (c % 2 == 1);
      tick("m1_step");
    end
    SHIFT = 0; KEEP = 0;

    // mode 0 first-pixel pens
    MODE_IS_0 = 1;
    LOAD = 1; D = 8'h02; tick("m0_load"); LOAD = 0; tick("m0_a"); tick("m0_b");
    check("m0_pen8", COLOUR, pal_val(8));
    LOAD = 1; D = 8'h80; tick("m0_load"); LOAD = 0; tick("m0_a"); tick("m0_b");
    check("m0_pen1", COLOUR, pal_val(1));
    LOAD = 1; D = 8'hAA; tick("m0_load"); LOAD = 0; tick("m0_a"); tick("m0_b");
    check("m0_pen15", COLOUR, pal_val(15));
    MODE_IS_0 = 0;

    // border palette entry and ignored function code
    reg_write(8'h10);
    reg_write(8'h4B);
    INK_SEL = 0; BORDER_SEL = 1; tick("border");
    check("border_0B", COLOUR, 11);
    reg_write(8'hC0);
    check("ignored_fn", COLOUR, 11);
    BORDER_SEL = 0; INK_SEL = 1; tick("ink_back");

    // colour hold while palette, pen and shifter change
    held = COLOUR;
    COLOUR_KEEP = 1; LOAD = 1; D = 8'hFF;
    reg_write(8'h00);
    check("keep1", COLOUR, int'(held));
    LOAD = 0;
    reg_write(8'h5F);
    check("keep2", COLOUR, int'(held));
    BORDER_SEL = 1; tick("keep3");
    check("keep3_const", COLOUR, int'(held));
    COLOUR_KEEP = 0; BORDER_SEL = 0;

    // LOAD beats SHIFT on the same edge
    MODE_IS_2 = 1;
    LOAD = 1; SHIFT = 1; D = 8'h80; tick("ld_sh");
    LOAD = 0; SHIFT = 0; KEEP = 0; tick("ld_sh_a"); tick("ld_sh_b");
    check("load_wins", COLOUR, 11);

    // asynchronous reset in the middle of a shifting line
    LOAD = 1; D = 8'hFF; tick("pre_rst_load");
    LOAD = 0; SHIFT = 1; tick("pre_rst_a"); tick("pre_rst_b");
    #3 RESET_n = 1'b0;
    #1 check("async_reset", COLOUR, 20);
    model_reset();
    #2 RESET_n = 1'b1;
    SHIFT = 0; KEEP = 1; INK_SEL = 1;
    tick("post_reset");
    check("post_reset_pen0", COLOUR, 20);
    KEEP = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 2);
      MODE_IS_0   = (r == 0);
      MODE_IS_2   = (r == 1);
      D           = 8'($urandom);
      LOAD        = ($urandom_range(0, 7) == 0);
      SHIFT       = $urandom_range(0, 1) == 1;
      KEEP        = ($urandom_range(0, 3) == 0);
      INK_SEL     = $urandom_range(0, 1) == 1;
      BORDER_SEL  = ($urandom_range(0, 4) == 0);
      COLOUR_KEEP = ($urandom_range(0, 5) == 0);
      REG_WR      = ($urandom_range(0, 3) == 0);
      REG_DATA    = 8'($urandom);
      tick("random");
    end
    REG_WR = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
